// File: rtl/ac3_quant_ctrl_if.sv
// Result readout handshake between the AC3 sequencer and its consumer.
// The master presents valid/sel; the slave answers with ready.
interface ac3_quant_ctrl_if #(
    parameter int NREG = 4
);
    localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

    logic          valid;
    logic [SW-1:0] sel;
    logic          ready;

    modport master (output valid, output sel, input ready);
    modport slave  (input valid, input sel, output ready);
endinterface

// File: rtl/ac3_quant_ctrl.sv
// Sequencer for the AC3 accumulate/quantize registers.
// One pass: clear, gated writes, arithmetic shifts, indexed readout.
module ac3_quant_ctrl #(
    parameter int W    = 22,
    parameter int NREG = 4,
    parameter int SHW  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [SHW-1:0] shift_amt,
    input  logic           acc_valid,
    input  logic           acc_last,
    output logic           cl_en,
    output logic           w_en,
    output logic           s_en,
    output logic           busy,
    output logic           done,
    ac3_quant_ctrl_if.master out
);
    localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [SHW-1:0] SH_MAX  = SHW'(W - 1);
    localparam logic [SW-1:0]  SEL_END = SW'(NREG - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, ACCUM, SHIFT, OUTPUT
    } state_t;

    state_t         st, nxt;
    logic [SHW-1:0] sh_cnt;
    logic [SW-1:0]  sel_q;
    logic           done_q;
    logic           acc_ok;
    logic           out_end;

    assign acc_ok  = (st == OUTPUT) && out.ready;
    assign out_end = acc_ok && (sel_q == SEL_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            sh_cnt <= '0;
            sel_q  <= '0;
            done_q <= 1'b0;
        end else begin
            st     <= nxt;
            done_q <= out_end && !abort;
            if (abort) begin
                sh_cnt <= '0;
                sel_q  <= '0;
            end else begin
                if (st == IDLE && start)
                    sh_cnt <= (shift_amt > SH_MAX) ? SH_MAX : shift_amt;
                else if (st == SHIFT)
                    sh_cnt <= sh_cnt - 1'b1;
                if (out_end)
                    sel_q <= '0;
                else if (acc_ok)
                    sel_q <= sel_q + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = st;
        if (abort) begin
            nxt = IDLE;
        end else begin
            unique case (st)
                IDLE:   if (start) nxt = CLEAR;
                CLEAR:  nxt = ACCUM;
                ACCUM:
                    if (acc_valid && acc_last)
                        nxt = (sh_cnt != '0) ? SHIFT : OUTPUT;
                SHIFT:  if (sh_cnt <= SHW'(1)) nxt = OUTPUT;
                OUTPUT: if (out_end) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // w_en is the only Mealy output: it follows acc_valid inside ACCUM.
    always_comb begin
        cl_en     = 1'b0;
        w_en      = 1'b0;
        s_en      = 1'b0;
        out.valid = 1'b0;
        unique case (1'b1)
            (st == CLEAR):  cl_en     = 1'b1;
            (st == ACCUM):  w_en      = acc_valid;
            (st == SHIFT):  s_en      = 1'b1;
            (st == OUTPUT): out.valid = 1'b1;
            default: ;
        endcase
    end

    assign out.sel = sel_q;
    assign busy    = (st != IDLE);
    assign done    = done_q;
endmodule

// File: tb/tb_ac3_quant_ctrl.sv
// Directed bench for ac3_quant_ctrl.
// Expected values are hand-derived from the pass timing.
module tb_ac3_quant_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] shift_amt = '0;
    logic       acc_valid = 1'b0;
    logic       acc_last = 1'b0;
    logic       cl_en, w_en, s_en, busy, done;

    int ncmp = 0;
    int nerr = 0;
    int n_cl = 0;
    int n_w  = 0;
    int n_s  = 0;
    int n_mx = 0;

    ac3_quant_ctrl_if #(.NREG(4)) oif ();

    ac3_quant_ctrl #(.W(22), .NREG(4), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .shift_amt (shift_amt),
        .acc_valid (acc_valid),
        .acc_last  (acc_last),
        .cl_en     (cl_en),
        .w_en      (w_en),
        .s_en      (s_en),
        .busy      (busy),
        .done      (done),
        .out       (oif.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cl_en) n_cl <= n_cl + 1;
        if (w_en)  n_w  <= n_w + 1;
        if (s_en)  n_s  <= n_s + 1;
        if (int'(cl_en) + int'(w_en) + int'(s_en) > 1)
            n_mx <= n_mx + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, " cl_en"}, 32'(cl_en), 0);
        chk({tag, " w_en"}, 32'(w_en), 0);
        chk({tag, " s_en"}, 32'(s_en), 0);
        chk({tag, " valid"}, 32'(oif.valid), 0);
        chk({tag, " sel"}, 32'(oif.sel), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    task automatic run_pass(input string tag, input int sa, input int nb,
                            input int es, input bit tog);
        int c0, w0, s0, k, g;
        c0 = n_cl; w0 = n_w; s0 = n_s;
        shift_amt = 5'(sa);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " clear"}, 32'(cl_en), 1);
        chk({tag, " busy"}, 32'(busy), 1);
        tick();
        acc_valid = 1'b0;
        acc_last = 1'b1;
        #1 chk({tag, " lastnov"}, 32'(w_en), 0);
        tick();
        chk({tag, " stay acc"}, 32'({s_en, oif.valid}), 0);
        for (int b = 0; b < nb; b++) begin
            acc_valid = 1'b1;
            acc_last = (b == nb - 1);
            #1 chk({tag, " w_en"}, 32'(w_en), 1);
            tick();
        end
        acc_valid = 1'b0;
        acc_last = 1'b0;
        for (int i = 0; i < es; i++) begin
            chk({tag, " shift"}, 32'({s_en, oif.valid}), 32'b10);
            tick();
        end
        chk({tag, " out first"}, 32'({s_en, oif.valid}), 32'b01);
        k = 0;
        g = 0;
        while (k < 4 && g < 20) begin
            oif.ready = tog ? g[0] : 1'b1;
            #1;
            chk({tag, " out valid"}, 32'(oif.valid), 1);
            chk({tag, " out sel"}, 32'(oif.sel), 32'(k));
            if (oif.ready) k++;
            tick();
            g++;
        end
        oif.ready = 1'b0;
        chk({tag, " accepts"}, 32'(k), 4);
        chk({tag, " done"}, 32'(done), 1);
        idle_outs({tag, " end"});
        tick();
        chk({tag, " done pulse"}, 32'(done), 0);
        chk({tag, " n_cl"}, 32'(n_cl - c0), 1);
        chk({tag, " n_w"}, 32'(n_w - w0), 32'(nb));
        chk({tag, " n_s"}, 32'(n_s - s0), 32'(es));
    endtask

    initial begin
        oif.ready = 1'b0;
        #2;
        idle_outs("reset");
        chk("reset done", 32'(done), 0);
        #10 rst_n = 1'b1;
        tick();

        run_pass("p3", 3, 5, 3, 1'b0);
        run_pass("p0", 0, 2, 0, 1'b0);
        run_pass("p31", 31, 1, 21, 1'b0);
        run_pass("tog", 2, 3, 2, 1'b1);

        // abort in the 2nd shift cycle, then a normal pass
        shift_amt = 5'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        acc_valid = 1'b1;
        acc_last = 1'b1;
        tick();
        acc_valid = 1'b0;
        acc_last = 1'b0;
        chk("ab sh1", 32'(s_en), 1);
        tick();
        abort = 1'b1;
        #1 chk("ab sh2", 32'(s_en), 1);
        tick();
        abort = 1'b0;
        idle_outs("ab next");
        chk("ab done", 32'(done), 0);
        tick();
        chk("ab done2", 32'(done), 0);
        run_pass("p1", 1, 2, 1, 1'b0);

        // abort and start together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        idle_outs("abst");

        // abort in ACCUM: write in the abort cycle, nothing after
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        acc_valid = 1'b1;
        abort = 1'b1;
        #1 chk("abacc w_en", 32'(w_en), 1);
        tick();
        abort = 1'b0;
        #1 chk("abacc after", 32'(w_en), 0);
        chk("abacc busy", 32'(busy), 0);
        acc_valid = 1'b0;

        // reset mid-ACCUM
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        acc_valid = 1'b1;
        #1 chk("rst pre", 32'(w_en), 1);
        rst_n = 1'b0;
        #1;
        idle_outs("rst mid");
        chk("rst done", 32'(done), 0);
        acc_valid = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        chk("rst idle", 32'(busy), 0);

        // start / acc_valid while busy
        shift_amt = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        acc_valid = 1'b1;
        #1 chk("clr no w", 32'({cl_en, w_en}), 32'b10);
        acc_valid = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy start", 32'({cl_en, busy}), 32'b01);
        acc_valid = 1'b1;
        acc_last = 1'b1;
        tick();
        acc_last = 1'b0;
        #1 chk("sh no w", 32'({s_en, w_en}), 32'b10);
        tick();
        chk("sh 2nd", 32'(s_en), 1);
        tick();
        #1 chk("out no w", 32'({oif.valid, w_en}), 32'b10);
        acc_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle_outs("clean");

        chk("mutex", 32'(n_mx), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end
endmodule
